// File: rtl/mplc_fetch_if.sv
// Program-memory read port plus instruction-register handshake toward the execution core.
// The master side belongs to the fetch sequencer.
interface mplc_fetch_if #(
  parameter int DW = 18,
  parameter int AW = 12
);
  logic [AW-1:0] A;
  logic [DW-1:0] DQ;
  logic          IR_VALID;
  logic          IR_READY;
  logic [3:0]    IR_OPC;
  logic [1:0]    IR_MOD;
  logic [AW-1:0] IR_OPND;
  logic [AW-1:0] IR_PC;
  logic          EXEC_IDLE;
  logic          CR;

  modport master (
    output A, IR_VALID, IR_OPC, IR_MOD, IR_OPND, IR_PC,
    input  DQ, IR_READY, EXEC_IDLE, CR
  );

  modport slave (
    input  A, IR_VALID, IR_OPC, IR_MOD, IR_OPND, IR_PC,
    output DQ, IR_READY, EXEC_IDLE, CR
  );
endinterface

// File: rtl/mplc_fetch_seq.sv
// PLC fetch/sequencer: one IR per cycle after a 2-cycle start, jumps resolved locally (1 bubble),
// IR held stable while IR_VALID && !IR_READY; each scan is bounded by a step watchdog.
module mplc_fetch_seq #(
  parameter int            DW        = 18,
  parameter int            AW        = 12,
  parameter logic [3:0]    OP_JMP    = 4'hE,
  parameter logic [3:0]    OP_JMPC   = 4'hD,
  parameter logic [AW-1:0] END_ADDR  = 12'hFFF,
  parameter logic [15:0]   MAX_STEPS = 16'd4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  mplc_fetch_if.master bus,
  output logic        RUNNING,
  output logic        SCAN_DONE,
  output logic [15:0] SCAN_CNT,
  output logic        FAULT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_WAIT_CR = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic [AW-1:0] tgt;
  logic [15:0]   step;
  logic          ir_valid;
  logic [3:0]    ir_opc;
  logic [1:0]    ir_mod;
  logic [AW-1:0] ir_opnd;
  logic [AW-1:0] ir_pc;
  logic          scan_done;
  logic [15:0]   scan_cnt;

  logic [3:0]    dq_opc;
  logic [1:0]    dq_mod;
  logic [AW-1:0] dq_opnd;
  logic          slot_open;
  logic          core_quiet;
  logic          wd_trip;

  assign dq_opc     = bus.DQ[DW-1:DW-4];
  assign dq_mod     = bus.DQ[DW-5:DW-6];
  assign dq_opnd    = bus.DQ[AW-1:0];
  assign slot_open  = !ir_valid || bus.IR_READY;
  assign core_quiet = !ir_valid && bus.EXEC_IDLE;
  assign wd_trip    = (step >= MAX_STEPS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pc        <= '0;
      tgt       <= '0;
      step      <= '0;
      ir_valid  <= 1'b0;
      ir_opc    <= '0;
      ir_mod    <= '0;
      ir_opnd   <= '0;
      ir_pc     <= '0;
      scan_done <= 1'b0;
      scan_cnt  <= '0;
    end else begin
      scan_done <= 1'b0;
      // An accepted IR retires unless the RUN slot below reloads it.
      if (ir_valid && bus.IR_READY)
        ir_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_RUN;
            step  <= '0;
            pc    <= '0;
          end
        end

        S_RUN: begin
          if (wd_trip) begin
            state    <= S_FAULT;
            ir_valid <= 1'b0;
          end else if (slot_open) begin
            if (dq_opc == OP_JMP) begin
              if (dq_opnd == END_ADDR) begin
                state <= S_DRAIN;
              end else begin
                pc   <= dq_opnd;
                step <= step + 16'd1;
              end
            end else if (dq_opc == OP_JMPC) begin
              // Target is latched so the decision does not depend on DQ staying put.
              tgt   <= dq_opnd;
              state <= S_WAIT_CR;
            end else begin
              ir_opc   <= dq_opc;
              ir_mod   <= dq_mod;
              ir_opnd  <= dq_opnd;
              ir_pc    <= pc;
              ir_valid <= 1'b1;
              pc       <= pc + PC_ONE;
              step     <= step + 16'd1;
            end
          end
        end

        S_WAIT_CR: begin
          if (wd_trip) begin
            state    <= S_FAULT;
            ir_valid <= 1'b0;
          end else if (core_quiet) begin
            pc    <= bus.CR ? tgt : pc + PC_ONE;
            step  <= step + 16'd1;
            state <= S_RUN;
          end
        end

        S_DRAIN: begin
          if (core_quiet) begin
            scan_done <= 1'b1;
            scan_cnt  <= scan_cnt + 16'd1;
            pc        <= '0;
            step      <= '0;
            state     <= STOP ? S_IDLE : S_RUN;
          end
        end

        S_FAULT: begin
          ir_valid <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.A        = pc;
  assign bus.IR_VALID = ir_valid;
  assign bus.IR_OPC   = ir_opc;
  assign bus.IR_MOD   = ir_mod;
  assign bus.IR_OPND  = ir_opnd;
  assign bus.IR_PC    = ir_pc;

  assign RUNNING   = (state == S_RUN) || (state == S_WAIT_CR) || (state == S_DRAIN);
  assign FAULT     = (state == S_FAULT);
  assign SCAN_DONE = scan_done;
  assign SCAN_CNT  = scan_cnt;

endmodule

// File: tb/tb_mplc_fetch_seq.sv
// Directed bench for mplc_fetch_seq: stimulus queues expected IR transfers, a negedge monitor checks them.
module tb_mplc_fetch_seq;
  localparam int DW = 18;
  localparam int AW = 12;
  localparam logic [3:0] OPC_LD = 4'h1, OPC_OR = 4'h3, OPC_ST = 4'h5, OPC_JMPC = 4'hD, OPC_JMP = 4'hE;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        STOP;
  logic        RUNNING;
  logic        SCAN_DONE;
  logic [15:0] SCAN_CNT;
  logic        FAULT;

  mplc_fetch_if #(.DW(DW), .AW(AW)) bus ();

  mplc_fetch_seq #(
    .DW(DW), .AW(AW), .OP_JMP(4'hE), .OP_JMPC(4'hD),
    .END_ADDR(12'hFFF), .MAX_STEPS(16'd8)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .bus(bus.master),
    .RUNNING(RUNNING), .SCAN_DONE(SCAN_DONE), .SCAN_CNT(SCAN_CNT), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [0:4095];
  assign bus.DQ = mem[bus.A];

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   hit;

  function automatic logic [DW-1:0] ins(input logic [3:0] o, input logic [1:0] m, input logic [AW-1:0] a);
    return {o, m, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [DW-1:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    q.push_back(e);
  endtask

  task automatic fill(input logic [DW-1:0] w);
    for (int i = 0; i < 4096; i++) mem[i] = w;
  endtask

  task automatic load_prog1();
    fill(ins(OPC_JMP, 2'd0, 12'hFFF));
    mem[0] = ins(OPC_LD, 2'd0, 12'h000);
    mem[1] = ins(OPC_OR, 2'd0, 12'h001);
    mem[2] = ins(OPC_ST, 2'd0, 12'h006);
    mem[3] = ins(OPC_JMP, 2'd0, 12'hFFF);
  endtask

  task automatic push_prog1_scan();
    push(12'h000, 18'h04000);
    push(12'h001, 18'h0C001);
    push(12'h002, 18'h14006);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    START = 1'b0;
    STOP = 1'b0;
    bus.IR_READY = 1'b0;
    bus.EXEC_IDLE = 1'b0;
    bus.CR = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_scan_done(input string name);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge CLK);
      #1 hit = (SCAN_DONE === 1'b1);
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  // Scoreboard monitor: a transfer happens on the next rising edge.
  always @(negedge CLK) begin
    if (!RST && bus.IR_VALID && bus.IR_READY) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ir: got IR_PC=%0h, required no transfer", bus.IR_PC);
      end else begin
        mon_e = q.pop_front();
        check("ir_pc", {20'd0, bus.IR_PC}, {20'd0, mon_e.pc});
        check("ir_word", {14'd0, bus.IR_OPC, bus.IR_MOD, bus.IR_OPND}, {14'd0, mon_e.word});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    // Reset state
    load_prog1();
    do_reset();
    check("rst_ir_valid", {31'd0, bus.IR_VALID}, 32'd0);
    check("rst_ir_fields", {14'd0, bus.IR_OPC, bus.IR_MOD, bus.IR_OPND}, 32'd0);
    check("rst_ir_pc", {20'd0, bus.IR_PC}, 32'd0);
    check("rst_addr", {20'd0, bus.A}, 32'd0);
    check("rst_flags", {28'd0, SCAN_DONE, FAULT, RUNNING, 1'b0}, 32'd0);
    check("rst_scan_cnt", {16'd0, SCAN_CNT}, 32'd0);

    // Straight-line scan, back-pressure at address 1, STOP during the second scan
    bus.IR_READY = 1'b1;
    bus.EXEC_IDLE = 1'b1;
    push_prog1_scan();
    push_prog1_scan();
    pulse_start();
    check("start_running", {31'd0, RUNNING}, 32'd1);
    check("start_no_ir_yet", {31'd0, bus.IR_VALID}, 32'd0);
    @(posedge CLK);
    #1 check("first_ir_latency", {31'd0, bus.IR_VALID}, 32'd1);
    check("first_ir_pc", {20'd0, bus.IR_PC}, 32'd0);
    @(posedge CLK);
    #1 check("second_ir_pc", {20'd0, bus.IR_PC}, 32'd1);
    bus.IR_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1 check("hold_ir", {bus.IR_VALID, 1'b0, bus.IR_OPC, bus.IR_OPND, bus.IR_PC}, {1'b1, 1'b0, 4'h3, 12'h001, 12'h001});
    end
    bus.IR_READY = 1'b1;
    @(posedge CLK);
    #1 check("after_hold_pc", {19'd0, bus.IR_VALID, bus.IR_PC}, {19'd0, 1'b1, 12'h002});
    wait_scan_done("scan1_done");
    check("scan1_cnt", {16'd0, SCAN_CNT}, 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge CLK);
      #1 hit = (bus.IR_VALID === 1'b1) && (bus.IR_PC == 12'h001);
    end
    check("scan2_at_addr1", {31'd0, hit}, 32'd1);
    STOP = 1'b1;
    wait_scan_done("scan2_done");
    check("scan2_cnt", {16'd0, SCAN_CNT}, 32'd2);
    @(posedge CLK);
    #1 check("stop_idle", {30'd0, SCAN_DONE, RUNNING}, 32'd0);
    check("stop_addr", {20'd0, bus.A}, 32'd0);
    STOP = 1'b0;
    repeat (4) @(posedge CLK);
    #1 check("prog1_queue_empty", q.size(), 32'd0);
    check("prog1_still_idle", {31'd0, RUNNING}, 32'd0);

    // Conditional jump with the core busy for 4 cycles
    do_reset();
    load_prog1();
    mem[3] = ins(OPC_JMPC, 2'd0, 12'h005);
    mem[4] = ins(OPC_LD, 2'd0, 12'h002);
    mem[5] = ins(OPC_ST, 2'd0, 12'h007);
    mem[6] = ins(OPC_JMP, 2'd0, 12'hFFF);
    bus.IR_READY = 1'b1;
    bus.EXEC_IDLE = 1'b0;
    bus.CR = 1'b1;
    push_prog1_scan();
    push(12'h005, 18'h14007);
    push_prog1_scan();
    push(12'h004, 18'h04002);
    push(12'h005, 18'h14007);
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge CLK);
      #1 hit = (bus.A == 12'h003) && (bus.IR_VALID === 1'b0) && (RUNNING === 1'b1);
    end
    check("enter_wait_cr", {31'd0, hit}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("wait_cr_hold", {19'd0, bus.IR_VALID, bus.A}, {19'd0, 1'b0, 12'h003});
      @(posedge CLK);
      #1;
    end
    bus.EXEC_IDLE = 1'b1;
    wait_scan_done("jmpc_scan1_done");
    check("jmpc_scan1_cnt", {16'd0, SCAN_CNT}, 32'd1);
    bus.CR = 1'b0;
    STOP = 1'b1;
    wait_scan_done("jmpc_scan2_done");
    check("jmpc_scan2_cnt", {16'd0, SCAN_CNT}, 32'd2);
    STOP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check("jmpc_queue_empty", q.size(), 32'd0);

    // Watchdog: endless JMP 000 with a limit of 8 steps
    do_reset();
    fill(ins(OPC_JMP, 2'd0, 12'h000));
    bus.IR_READY = 1'b1;
    bus.EXEC_IDLE = 1'b1;
    START = 1'b1;
    repeat (5) @(posedge CLK);
    #1 check("wd_not_early", {30'd0, FAULT, RUNNING}, 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge CLK);
      #1 hit = (FAULT === 1'b1);
    end
    check("wd_fault", {31'd0, hit}, 32'd1);
    check("wd_outputs", {30'd0, RUNNING, bus.IR_VALID}, 32'd0);
    repeat (5) @(posedge CLK);
    #1 check("wd_sticky", {30'd0, FAULT, RUNNING}, 32'd2);
    START = 1'b0;

    // Reset while an IR is pending in RUN
    do_reset();
    load_prog1();
    check("rst_clears_fault", {31'd0, FAULT}, 32'd0);
    bus.IR_READY = 1'b1;
    bus.EXEC_IDLE = 1'b1;
    push_prog1_scan();
    pulse_start();
    wait_scan_done("rst_scan_done");
    bus.IR_READY = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge CLK);
      #1 hit = (bus.IR_VALID === 1'b1);
    end
    check("rst_pre_ir_valid", {31'd0, hit}, 32'd1);
    check("rst_pre_cnt", {16'd0, SCAN_CNT}, 32'd1);
    RST = 1'b1;
    #1 check("rst_async_ir", {31'd0, bus.IR_VALID}, 32'd0);
    check("rst_async_addr", {20'd0, bus.A}, 32'd0);
    check("rst_async_cnt", {16'd0, SCAN_CNT}, 32'd0);
    check("rst_async_running", {31'd0, RUNNING}, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check("rst_queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
